predictor_history_tracker: RTL
==============================

PREDICTOR_HISTORY_TRACKER -- requirements
Module: predictor_history_tracker

Interface
REQ-001 SHALL have parameter DEPTH, default 8, in-flight branch queue entries (power of 2, 2..32).
REQ-002 SHALL have port clock  input  1  sole clock; all state updates on posedge.
REQ-003 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have ports fetch_valid input 1, fetch_pc input 64, and fetch_ready output 1: new branch to predict.
REQ-005 SHALL have ports req_valid output 1, req_pc output 64, and req_hist output 64: request to the downstream branch predictor harness.
REQ-006 SHALL have port req_taken  input  1  harness prediction, valid the cycle after req_valid.
REQ-007 SHALL have ports resp_valid output 1 and resp_taken output 1: prediction returned to fetch.
REQ-008 SHALL have ports resolve_valid input 1, resolve_taken input 1, and resolve_ready output 1: in-order outcome of the oldest branch.
REQ-009 SHALL have ports update_valid output 1, update_pc output 64, update_hist output 64, and update_taken output 1: training to the harness.
REQ-010 SHALL have port mispredict  output 1  one-cycle pulse on a resolved misprediction.

Function
REQ-011 SHALL keep a 64-bit speculative global history ghist (newest outcome in bit 0) and a FIFO of DEPTH entries {pc[63:0], hist[63:0], pred, pred_known}.
REQ-012 SHALL run a two-state FSM, IDLE and WAIT; fetch_ready = (state==IDLE) && (count<DEPTH).
REQ-013 SHALL, on fetch fire (fetch_valid && fetch_ready), combinationally drive req_valid=1, req_pc=fetch_pc, req_hist=ghist, push {fetch_pc, ghist, 0, 0} at the tail, and go to WAIT.
REQ-014 SHALL drive req_valid=0 whenever no fetch fire occurs; req_pc/req_hist are don't-care then.
REQ-015 SHALL, in WAIT, sample req_taken, set the tail-minus-one entry's pred=req_taken and pred_known=1, set ghist={ghist[62:0],req_taken}, drive resp_valid=1 and resp_taken=req_taken combinationally that cycle, and return to IDLE.
REQ-016 SHALL accept at most one fetch per two cycles (1-cycle predict latency, no overlap).
REQ-017 SHALL drive resolve_ready=1 iff count>0 and the head entry has pred_known=1.
REQ-018 SHALL, on resolve fire, pop the head and register update_valid=1, update_pc=head.pc, update_hist=head.hist, update_taken=resolve_taken for exactly the next cycle.
REQ-019 SHALL, on resolve fire with resolve_taken != head.pred, flush all entries (count=0, pointers equal), set ghist={head.hist[62:0],resolve_taken}, force state IDLE, suppress resp_valid that cycle, and register mispredict=1 for the next cycle.
REQ-020 SHALL, on a mispredicting resolve in the same cycle as a fetch fire, discard the fetch (no push, no state change beyond REQ-019); req_valid still follows REQ-013 and the harness result is ignored.
REQ-021 SHALL, for a correct resolve in the same cycle as a push, leave count unchanged; pointers wrap modulo DEPTH.
REQ-022 SHALL, with a correct resolve and WAIT capture in the same cycle, apply both: ghist updated per REQ-015 and head popped.
REQ-023 SHALL never push when count==DEPTH and never pop when count==0.

Reset
REQ-024 SHALL, while reset is high at a clock edge, set ghist=0, count=0, pointers=0, state=IDLE, and update_valid=mispredict=0; reset overrides all same-cycle events and in-flight predictions are dropped.
REQ-025 SHALL hold every output at 0 in the cycle after reset, except fetch_ready=1.

Verification
REQ-026 Single branch: fetch pc=0x1000 after reset -> req_hist=0; req_taken=1 next cycle -> resp_taken=1, ghist=0x1; resolve taken=1 -> next cycle update_pc=0x1000, update_hist=0, update_taken=1, mispredict=0.
REQ-027 Fill: 8 fetches with alternating predictions and no resolves -> fetch_ready=0 after the 8th capture; one correct resolve -> fetch_ready=1 next cycle.
REQ-028 Mispredict: 3 entries predicted 1,1,1 from ghist=0; resolve head taken=0 -> mispredict pulse, count=0, ghist=0x0, next fetch req_hist=0.
REQ-029 Resolve gating: resolve_valid=1 while the head prediction is pending -> resolve_ready=0 and no pop until the capture cycle.
REQ-030 Reset mid-flight: assert reset in WAIT with 3 entries queued -> after reset count=0, no resp_valid, no update_valid, fetch_ready=1.
REQ-031 Wrap: 20 push/resolve pairs with DEPTH=8 -> update_pc sequence matches fetch order exactly.

Source files
------------

// File: rtl/predictor_history_tracker.sv
// predictor_history_tracker: speculative global history plus in-flight branch queue
// between fetch, a one-cycle branch predictor harness and in-order resolution.
module predictor_history_tracker #(
  parameter int DEPTH = 8
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        fetch_valid,
  input  logic [63:0] fetch_pc,
  output logic        fetch_ready,
  output logic        req_valid,
  output logic [63:0] req_pc,
  output logic [63:0] req_hist,
  input  logic        req_taken,
  output logic        resp_valid,
  output logic        resp_taken,
  input  logic        resolve_valid,
  input  logic        resolve_taken,
  output logic        resolve_ready,
  output logic        update_valid,
  output logic [63:0] update_pc,
  output logic [63:0] update_hist,
  output logic        update_taken,
  output logic        mispredict
);
  localparam int AW = $clog2(DEPTH);
  typedef enum logic {IDLE, WAIT} state_t;
  state_t state, state_next;
  logic [AW-1:0] head, tail, last;
  logic [AW:0] count;
  logic [63:0] ghist, ghist_next;
  logic [63:0] pc_q [DEPTH];
  logic [63:0] hist_q [DEPTH];
  logic [DEPTH-1:0] pred_q, known_q;
  logic fire, pop, mis, capture, push;
  always_comb begin
    fetch_ready = state == IDLE && count < (AW+1)'(DEPTH);
    fire = fetch_valid && fetch_ready;
    resolve_ready = count != '0 && known_q[head];
    pop = resolve_valid && resolve_ready;
    mis = pop && resolve_taken != pred_q[head];
    capture = state == WAIT;
    push = fire && !mis;
    last = tail - AW'(1);
    req_valid = fire;
    req_pc = fire ? fetch_pc : '0;
    req_hist = fire ? ghist : '0;
    resp_valid = capture && !mis;
    resp_taken = resp_valid && req_taken;
    // A misprediction rebuilds history from the checkpoint taken when the head was fetched
    ghist_next = mis ? {hist_q[head][62:0], resolve_taken} : capture ? {ghist[62:0], req_taken} : ghist;
    state_next = mis ? IDLE : push ? WAIT : capture ? IDLE : state;
  end
  always_ff @(posedge clock)
    if (reset) state <= IDLE;
    else state <= state_next;
  always_ff @(posedge clock) begin
    if (reset) begin
      ghist <= '0;
      head <= '0;
      tail <= '0;
      count <= '0;
      update_valid <= 1'b0;
      update_pc <= '0;
      update_hist <= '0;
      update_taken <= 1'b0;
      mispredict <= 1'b0;
    end else begin
      ghist <= ghist_next;
      update_valid <= pop;
      update_pc <= pop ? pc_q[head] : '0;
      update_hist <= pop ? hist_q[head] : '0;
      update_taken <= pop && resolve_taken;
      mispredict <= mis;
      head <= mis ? '0 : head + AW'(pop);
      tail <= mis ? '0 : tail + AW'(push);
      count <= mis ? '0 : count + (AW+1)'(push) - (AW+1)'(pop);
    end
  end
  always_ff @(posedge clock) begin
    if (push) begin
      pc_q[tail] <= fetch_pc;
      hist_q[tail] <= ghist;
      pred_q[tail] <= 1'b0;
      known_q[tail] <= 1'b0;
    end
    if (capture && !mis) begin
      pred_q[last] <= req_taken;
      known_q[last] <= 1'b1;
    end
  end
endmodule
